aes_inv_key_schedule: RTL and testbench
=======================================

// Module: aes_inv_key_schedule
// PURPOSE
//  Iterative AES-128 inverse key schedule for the decryption datapath.
//  Accepts the final (round-10) round key and streams round keys 10,9,...,0 in
//  reverse order over a valid/ready interface, one key per step.
//  Feeds the inverse-cipher round engine, which consumes keys last-to-first.
// PARAMETERS
//  NR     10  number of rounds; the step from round r to r-1 uses RCON[r]; only 10 supported
//  RND_W  4   width of round index output
// PORTS
//  clk        in   1    single clock, all state on posedge
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    in_key valid
//  in_ready   out  1    block idle, can accept a key
//  in_key     in   128  round-NR key {w0,w1,w2,w3}, w0 = [127:96]
//  out_valid  out  1    out_key/out_round valid
//  out_ready  in   1    downstream accepts current key
//  out_key    out  128  round key for round out_round
//  out_round  out  4    round index of out_key, NR down to 0
//  out_last   out  1    high with out_valid when out_round==0
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_last=0, out_round=0, out_key=0; in_ready=1 in IDLE.
//  FSM states: IDLE -> EMIT -> SUB -> UPD -> EMIT ... -> IDLE.
//   IDLE: in_ready=1. On in_valid: key_r<=in_key, round_r<=NR, go EMIT.
//   EMIT: out_valid=1. Key/round/last held stable until out_ready.
//     On out_ready: round_r==0 -> IDLE, else -> SUB.
//   SUB: t3=w3^w2. Drive 4 SBox byte lookups with RotWord(t3)={t3[23:0],t3[31:24]}.
//     SBox valid_in=1. SBox output is available next cycle.
//   UPD: new w3=w3^w2, w2=w2^w1, w1=w1^w0, w0=w0^SubWord^RCON[round_r].
//     Register new key, round_r<=round_r-1, go EMIT.
//  Latency (out_ready=1): key accepted at cycle 0, round 10 valid at cycle 1.
//   Each further key takes 3 cycles; round 0 valid at cycle 31.
//   IDLE (in_ready=1) again at cycle 32.
//  in_ready=0 in all states except IDLE. in_valid while busy is ignored, not queued.
//  Handshake: a transfer occurs on out_valid&&out_ready. out_valid never drops without a transfer.
//  out_ready may be low for any number of cycles, including while out_valid=0.
//  out_round wraps never: step from round 0 is impossible; round 0 transfer always returns to IDLE.
//  Reset mid-stream: next cycle IDLE, out_valid=0, partial sequence discarded.
//   No key is emitted from the aborted stream.
//  Simultaneous reset and in_valid: reset wins, key not captured.
//  Only out_valid drives the data contract; out_key/out_round are don't-care when out_valid=0.
//   Both still hold their last value.
// STRUCTURE
//  aes_pkg: RCON[1:10] 32-bit words, MSB byte 01,02,04,08,10,20,40,80,1B,36.
//   aes_pkg also holds the FSM state typedef/localparams and AES_KEY_W=128.
//  Sub-modules: 4 instances of existing clocked SBox (byte lookup, 1-cycle latency).
//   SBox reset port driven by ~reset.
//  One natural helper: aes_inv_key_step (combinational UPD XOR network).
// TESTING
//  1 FIPS-197 A.1: in_key=d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready=1.
//    -> r10 at cycle 1, r9=ac7766f319fadc2128d12941575c006e at cycle 4.
//    -> r1=a0fafe1788542cb123a339392a6c7605, r0=2b7e151628aed2a6abf7158809cf4f3c at cycle 31.
//    -> out_last=1 only on r0.
//  2 Backpressure: same key, out_ready randomly low ~50%.
//    -> same 11 keys in order, out_key stable while out_valid&&!out_ready, none dropped or duplicated.
//  3 Busy-ignore: in_valid=1 with a different key throughout stream.
//    -> in_ready=0 until after r0; the second key is accepted only on return to IDLE.
//  4 Zero key: in_key=b4ef5bcb3e92e21123e951cf6f8f188e -> r0=0 at cycle 31.
//  5 Reset mid-stream: assert reset 1 cycle while out_round=6.
//    -> out_valid=0 next cycle, in_ready=1.
//    -> a new FIPS key then yields the full correct sequence.
//  6 Round-trip: random 128-bit key through the forward key expansion chain to r10, then into this block.
//    -> r0 equals the original key (1000 iterations).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule round constants and the inverse key schedule FSM encoding.
package aes_pkg;

  localparam int unsigned AES_KEY_W = 128;

  // Round constant words, indexed by the round being stepped away from.
  localparam logic [31:0] RCON [1:10] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StSub,
    StUpd
  } key_sched_state_e;

  function automatic logic [31:0] get_rcon(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10) begin
      return RCON[round];
    end
    return '0;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// Combinational inverse key-schedule step: recovers round key r-1 from round key r.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic [31:0]          sub_word,
  input  logic [31:0]          rcon,
  output logic [AES_KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;

  assign {w0, w1, w2, w3} = key_in;
  assign key_out = {w0 ^ sub_word ^ rcon, w1 ^ w0, w2 ^ w1, w3 ^ w2};

endmodule

// File: rtl/aes_sbox.sv
// Registered AES forward S-box: one byte lookup, result valid the cycle after valid_in.
module aes_sbox (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  // Entry 0x00 sits in the top byte, so the lookup index is the bitwise inverse of the input.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= 8'h00;
    end else if (valid_in) begin
      data_out <= SBOX[~data_in];
    end
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: takes the round-10 key and streams keys 10 down to 0.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NR    = 10,
  parameter int unsigned RND_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_KEY_W-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_KEY_W-1:0] out_key,
  output logic [RND_W-1:0]     out_round,
  output logic                 out_last
);

  key_sched_state_e     state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d, next_key;
  logic [RND_W-1:0]     round_q, round_d;
  logic [31:0]          t3, rot_word, sub_word;
  logic                 sbox_valid;

  // t3 equals the previous round's w3; its RotWord feeds the S-boxes during StSub.
  assign t3         = key_q[31:0] ^ key_q[63:32];
  assign rot_word   = {t3[23:0], t3[31:24]};
  assign sbox_valid = (state_q == StSub);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .clk      (clk),
      .reset_n  (~reset),
      .valid_in (sbox_valid),
      .data_in  (rot_word[8*i +: 8]),
      .data_out (sub_word[8*i +: 8])
    );
  end

  aes_inv_key_step u_step (
    .key_in   (key_q),
    .sub_word (sub_word),
    .rcon     (get_rcon(round_q)),
    .key_out  (next_key)
  );

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          key_d   = in_key;
          round_d = RND_W'(NR);
          state_d = StEmit;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        out_last  = (round_q == '0);
        if (out_ready) begin
          state_d = (round_q == '0) ? StIdle : StSub;
        end
      end
      StSub: state_d = StUpd;
      StUpd: begin
        key_d   = next_key;
        round_d = round_q - RND_W'(1);
        state_d = StEmit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign out_key   = key_q;
  assign out_round = round_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule, with an independent forward-expansion model.
module tb_aes_inv_key_schedule;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  logic [127:0] obs_key [0:10];

  aes_inv_key_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_key   (out_key),
    .out_round (out_round),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (GF(2^8) arithmetic, no lookup table) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    d = d >> (8 - n);
    return d[7:0];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] p = a;
    // a^254 is the multiplicative inverse (and maps 0 to 0).
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, s;
    {w0, w1, w2, w3} = k;
    t = {w3[23:0], w3[31:24]};
    s = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
    w0 = w0 ^ s ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] rk [0:10];

  task automatic expand(input logic [127:0] k0);
    logic [7:0] rc = 8'h01;
    rk[0] = k0;
    for (int i = 1; i <= 10; i++) begin
      rk[i] = fwd_step(rk[i-1], rc);
      rc = xtime(rc);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams the schedule whose round-0 key is k0 and checks every emitted key.
  // preloaded: the round-10 key was already captured on the previous edge.
  // busy: hold in_valid high with busy_key throughout, and let it be captured at the end.
  task automatic run_stream(input string tag, input logic [127:0] k0, input bit bp,
                            input bit preloaded, input bit busy,
                            input logic [127:0] busy_key);
    int r = 10;
    int cyc = 0;
    int guard = 0;
    expand(k0);
    if (!preloaded) begin
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      in_valid = 1'b1;
      in_key   = rk[10];
      step();
    end
    cyc      = 1;
    guard    = 0;
    in_valid = busy;
    in_key   = busy_key;
    while (r >= 0 && guard < 400) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (busy) chk({tag, " in_ready busy"}, 128'(in_ready), 128'(1'b0));
      if (out_valid) begin
        chk({tag, " key"}, out_key, rk[r]);
        chk({tag, " round"}, 128'(out_round), 128'(r));
        chk({tag, " last"}, 128'(out_last), 128'(r == 0));
        if (!bp) chk({tag, " cycle"}, 128'(cyc), 128'(1 + 3 * (10 - r)));
        if (out_ready) begin
          obs_key[r] = out_key;
          r--;
        end
      end
      step();
      cyc++;
      guard++;
    end
    if (r >= 0) begin
      errors++;
      $display("FAIL %s timeout observed round=%0d expected all rounds", tag, r);
    end
    chk({tag, " idle ready"}, 128'(in_ready), 128'(1'b1));
    chk({tag, " idle valid"}, 128'(out_valid), 128'(1'b0));
    if (!bp) chk({tag, " idle cycle"}, 128'(cyc), 128'(32));
    out_ready = 1'b1;
    if (busy) begin
      step();
      in_valid = 1'b0;
    end
  endtask

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    logic [127:0] rnd;
    int guard;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("reset valid", 128'(out_valid), 128'(1'b0));
    chk("reset last", 128'(out_last), 128'(1'b0));
    chk("reset round", 128'(out_round), 128'(0));
    chk("reset key", out_key, 128'h0);
    chk("reset ready", 128'(in_ready), 128'(1'b1));
    reset = 1'b0;
    step();

    // FIPS-197 A.1 with out_ready held high.
    run_stream("fips", FIPS_K0, 1'b0, 1'b0, 1'b0, '0);
    chk("fips r10", obs_key[10], FIPS_K10);
    chk("fips r9", obs_key[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("fips r1", obs_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips r0", obs_key[0], FIPS_K0);

    // Random backpressure on out_ready.
    run_stream("bp", FIPS_K0, 1'b1, 1'b0, 1'b0, '0);
    chk("bp r0", obs_key[0], FIPS_K0);

    // Busy-ignore: the zero-key round-10 key waits on in_valid and is taken on return to IDLE.
    in_valid = 1'b1;
    in_key   = FIPS_K10;
    step();
    run_stream("busy", FIPS_K0, 1'b0, 1'b1, 1'b1, ZERO_K10);
    run_stream("zero", 128'h0, 1'b0, 1'b1, 1'b0, '0);
    chk("zero r10", obs_key[10], ZERO_K10);
    chk("zero r0", obs_key[0], 128'h0);

    // Reset mid-stream while round 6 is being offered.
    in_valid = 1'b1;
    in_key   = FIPS_K10;
    step();
    in_valid = 1'b0;
    guard    = 0;
    while (!(out_valid && out_round == 4'd6) && guard < 100) begin
      step();
      guard++;
    end
    chk("midrst reached r6", 128'(out_round), 128'(6));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst valid", 128'(out_valid), 128'(1'b0));
    chk("midrst ready", 128'(in_ready), 128'(1'b1));
    step();
    chk("midrst no resume", 128'(out_valid), 128'(1'b0));
    run_stream("after rst", FIPS_K0, 1'b0, 1'b0, 1'b0, '0);

    // Reset and in_valid together: key must not be captured.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_key   = FIPS_K10;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst+valid ready", 128'(in_ready), 128'(1'b1));
    step();
    chk("rst+valid valid", 128'(out_valid), 128'(1'b0));

    // Round trip of random keys.
    for (int n = 0; n < 1000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_stream("roundtrip", rnd, 1'b0, 1'b0, 1'b0, '0);
      chk("roundtrip r0", obs_key[0], rnd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
